mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline register and writeback select for the 5-stage ARM CPU. Captures the MEM-stage result each cycle, handles stall and flush, and selects ALU result or load data. Produces the write address, write enable and write data that drive the register file's write-port decoder tree (2:4 / 3:8 decoders) and data inputs. Also keeps a retired-instruction counter for bench and debug use.

## Interface

- `DATA_W`, default 64: datapath width.
- `ADDR_W`, default 5: register address width. X31 is XZR.
- `CNT_W`, default 32: retire counter width.

Ports:

- `clk`, in, 1: the only clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `stall`, in, 1: hold all stage contents.
- `flush`, in, 1: replace the captured instruction with a bubble.
- `mem_valid`, in, 1: the MEM stage holds a real instruction.
- `mem_regwrite`, in, 1: the instruction writes a register.
- `mem_memtoreg`, in, 1: 1 selects load data, 0 selects the ALU result.
- `mem_rd`, in, ADDR_W: destination register.
- `mem_alu_result`, in, DATA_W: ALU result from EX/MEM.
- `mem_load_data`, in, DATA_W: data-memory read data.
- `wb_valid`, out, 1: the WB stage holds a real instruction.
- `wb_en`, out, 1: register-file write enable. Feeds the decoder `en`.
- `wb_rd`, out, ADDR_W: write address. Feeds the decoder `sel` bits.
- `wb_data`, out, DATA_W: write data.
- `retire_count`, out, CNT_W: number of valid instructions retired.

## Operation

- Stage registers: `valid_q`, `regwrite_q`, `rd_q`, `data_q`.
- Writeback mux runs at capture time: `data_q <= mem_memtoreg ? mem_load_data : mem_alu_result`.
  - The mux is not in the WB-to-regfile path.
- Update precedence on each rising edge, highest first:
  1. `!reset`: all stage registers and `retire_count` go to 0.
  2. `flush`: `valid_q`=0, `regwrite_q`=0. `rd_q` and `data_q` load 0.
  3. `stall`: all registers hold.
  4. Otherwise:
     - `valid_q`=`mem_valid`.
     - `regwrite_q`=`mem_valid & mem_regwrite`.
     - `rd_q`=`mem_rd`, and `data_q` as above.
- When `flush` and `stall` are asserted together, flush wins.
- Outputs:
  - `wb_valid`=`valid_q`.
  - `wb_rd`=`rd_q`.
  - `wb_data`=`data_q`.
  - `wb_en`=`valid_q & regwrite_q & (rd_q != 31) & !stall`.
- XZR suppression: a write to X31 never asserts `wb_en`. The instruction still retires.
- Retire counter: increments by 1 on each edge where `reset`=1, `valid_q`=1 and `stall`=0.
  - Wraps from all-ones to 0 with no flag.
  - The instruction being retired is the one currently in WB. Flush does not cancel it.
- `mem_valid`=0 with `mem_regwrite`=1 is a bubble. It must not write.

## Timing

- Latency: 1 cycle from MEM inputs to `wb_*` outputs.
- Reset values: `wb_valid`=0, `wb_en`=0, `wb_rd`=0, `wb_data`=0, `retire_count`=0.
- Reset is sampled only on `clk`. Asserting it mid-stream drops the WB instruction without counting it.
- `wb_en` is combinational from `stall`.
  - The regfile write lands on the same edge the stage would otherwise advance.
  - A stalled stage therefore never double-writes.
- No combinational path from `mem_*` to `wb_*`.
- Back-to-back valid instructions retire one per cycle with no gaps.

## Structure

- Shared package `cpu_pkg`:
  - `DATA_W`, `ADDR_W`, the constant `XZR = 5'd31`.
  - A packed struct `mem_wb_t` with fields valid, regwrite, rd, data, reused by the forwarding unit.
- One natural sub-module: `retire_counter`.
  - Parameterised width; enable and synchronous active-low reset.
- The rest is a single `always_ff` plus continuous assigns.

## Test plan

- Reset then ALU write:
  - Stimulus: hold `reset`=0 for 2 cycles, release; drive valid, regwrite, `memtoreg`=0, rd=5, alu=64'h1234.
  - Response: next cycle `wb_en`=1, `wb_rd`=5, `wb_data`=64'h1234, `retire_count`=0. One cycle later `retire_count`=1.
- Load write:
  - Stimulus: `memtoreg`=1, load=64'hDEAD_BEEF, alu=64'h1, rd=2.
  - Response: `wb_data`=64'hDEAD_BEEF, `wb_rd`=2, `wb_en`=1.
- XZR:
  - Stimulus: valid, regwrite, rd=31.
  - Response: `wb_valid`=1, `wb_en`=0, `retire_count` still increments.
- Stall/flush:
  - Stimulus: instruction A (rd=3) in WB; assert `stall` 3 cycles while MEM shows B (rd=4).
  - Response: `wb_rd`=3 throughout, `wb_en`=0, count unchanged.
  - Stimulus: release stall and assert `flush` and `stall` together for one cycle.
  - Response: next `wb_valid`=0, `wb_en`=0, `wb_data`=0.
- Counter wrap: with `CNT_W`=4, retire 17 valid instructions → `retire_count`=1.
- Reset mid-stream:
  - Stimulus: valid writes every cycle; pull `reset` low for one cycle.
  - Response: all outputs 0 the next cycle. Normal capture resumes the cycle after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared datapath widths, XZR encoding and the MEM/WB record type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  localparam logic [4:0] XZR = 5'd31;

  // Same field layout the forwarding unit consumes from the WB stage.
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } mem_wb_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module   : mem_wb_if
// Purpose  : MEM-side capture inputs, pipeline control and WB-side outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);

  logic              stall;
  logic              flush;

  logic              mem_valid;
  logic              mem_regwrite;
  logic              mem_memtoreg;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;

  logic              wb_valid;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  // Pipeline control and the upstream MEM stage drive the stage inputs.
  modport master (
    output stall,
    output flush,
    output mem_valid,
    output mem_regwrite,
    output mem_memtoreg,
    output mem_rd,
    output mem_alu_result,
    output mem_load_data,
    input  wb_valid,
    input  wb_en,
    input  wb_rd,
    input  wb_data
  );

  modport slave (
    input  stall,
    input  flush,
    input  mem_valid,
    input  mem_regwrite,
    input  mem_memtoreg,
    input  mem_rd,
    input  mem_alu_result,
    input  mem_load_data,
    output wb_valid,
    output wb_en,
    output wb_rd,
    output wb_data
  );

endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_retire_counter.sv
// ============================================================================
// Module   : retire_counter
// Purpose  : Free-running retired-instruction counter, wraps silently.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             en,
  output logic      [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register with capture-time writeback select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  mem_wb_if.slave               bus,
  output logic      [CNT_W-1:0] retire_count
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(XZR);

  logic              valid_q;
  logic              regwrite_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;

  logic [DATA_W-1:0] wb_sel;
  logic              retire_en;

  // Select at capture so the WB-to-regfile path carries no mux.
  assign wb_sel = bus.mem_memtoreg ? bus.mem_load_data : bus.mem_alu_result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else if (!bus.stall) begin
      valid_q    <= bus.mem_valid;
      regwrite_q <= bus.mem_valid & bus.mem_regwrite;
      rd_q       <= bus.mem_rd;
      data_q     <= wb_sel;
    end
  end

  assign bus.wb_valid = valid_q;
  assign bus.wb_rd    = rd_q;
  assign bus.wb_data  = data_q;

  // Gating with stall keeps a held instruction from writing on every stalled edge.
  assign bus.wb_en = valid_q & regwrite_q & (rd_q != ZERO_REG) & ~bus.stall;

  assign retire_en = valid_q & ~bus.stall;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .en    (retire_en),
    .count (retire_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Directed self-checking bench for mem_wb_stage (4-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] retire_count;

  int n_checks;
  int n_errors;

  mem_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_wb_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] ld);
    bus.mem_valid      = v;
    bus.mem_regwrite   = rw;
    bus.mem_memtoreg   = m2r;
    bus.mem_rd         = rd;
    bus.mem_alu_result = alu;
    bus.mem_load_data  = ld;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd9, 64'hFFFF, 64'hEEEE);

    // Reset held for two edges.
    step();
    step();
    check("rst_valid", {63'd0, bus.wb_valid}, 64'd0);
    check("rst_en",    {63'd0, bus.wb_en},    64'd0);
    check("rst_rd",    {59'd0, bus.wb_rd},    64'd0);
    check("rst_data",  bus.wb_data,           64'd0);
    check("rst_cnt",   {60'd0, retire_count}, 64'd0);

    // ALU write to X5.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 64'h5555);
    step();
    check("alu_en",   {63'd0, bus.wb_en},    64'd1);
    check("alu_rd",   {59'd0, bus.wb_rd},    64'd5);
    check("alu_data", bus.wb_data,           64'h1234);
    check("alu_cnt",  {60'd0, retire_count}, 64'd0);

    // Load write to X2.
    drive(1'b1, 1'b1, 1'b1, 5'd2, 64'h1, 64'hDEAD_BEEF);
    step();
    check("ld_cnt",  {60'd0, retire_count}, 64'd1);
    check("ld_data", bus.wb_data,           64'hDEAD_BEEF);
    check("ld_rd",   {59'd0, bus.wb_rd},    64'd2);
    check("ld_en",   {63'd0, bus.wb_en},    64'd1);

    // Write to XZR: retires but never enables the regfile.
    drive(1'b1, 1'b1, 1'b0, 5'd31, 64'h7, 64'h0);
    step();
    check("xzr_cnt",   {60'd0, retire_count}, 64'd2);
    check("xzr_valid", {63'd0, bus.wb_valid}, 64'd1);
    check("xzr_en",    {63'd0, bus.wb_en},    64'd0);

    // Instruction A to X3.
    drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h33, 64'h0);
    step();
    check("a_cnt", {60'd0, retire_count}, 64'd3);
    check("a_rd",  {59'd0, bus.wb_rd},    64'd3);
    check("a_en",  {63'd0, bus.wb_en},    64'd1);

    // Stall three edges with B (X4) waiting in MEM.
    drive(1'b1, 1'b1, 1'b0, 5'd4, 64'h44, 64'h0);
    bus.stall = 1'b1;
    #1;
    check("stall_en_comb", {63'd0, bus.wb_en}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rd",  {59'd0, bus.wb_rd},    64'd3);
      check("stall_en",  {63'd0, bus.wb_en},    64'd0);
      check("stall_cnt", {60'd0, retire_count}, 64'd3);
    end

    // Flush together with stall: flush wins, stalled edge does not retire.
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    #1;
    check("fl_valid", {63'd0, bus.wb_valid}, 64'd0);
    check("fl_en",    {63'd0, bus.wb_en},    64'd0);
    check("fl_data",  bus.wb_data,           64'd0);
    check("fl_rd",    {59'd0, bus.wb_rd},    64'd0);
    check("fl_cnt",   {60'd0, retire_count}, 64'd3);

    // B captured normally after the bubble; the bubble does not count.
    step();
    check("b_rd",   {59'd0, bus.wb_rd},    64'd4);
    check("b_en",   {63'd0, bus.wb_en},    64'd1);
    check("b_data", bus.wb_data,           64'h44);
    check("b_cnt",  {60'd0, retire_count}, 64'd3);

    // Mid-stream reset drops B without counting it.
    drive(1'b1, 1'b1, 1'b0, 5'd8, 64'h88, 64'h0);
    reset = 1'b0;
    step();
    check("mr_valid", {63'd0, bus.wb_valid}, 64'd0);
    check("mr_en",    {63'd0, bus.wb_en},    64'd0);
    check("mr_rd",    {59'd0, bus.wb_rd},    64'd0);
    check("mr_data",  bus.wb_data,           64'd0);
    check("mr_cnt",   {60'd0, retire_count}, 64'd0);

    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd6, 64'h66, 64'h0);
    step();
    check("rs_rd",   {59'd0, bus.wb_rd},    64'd6);
    check("rs_en",   {63'd0, bus.wb_en},    64'd1);
    check("rs_data", bus.wb_data,           64'h66);
    check("rs_cnt",  {60'd0, retire_count}, 64'd0);

    // 17 retirements on a 4-bit counter: 16 wraps to 0, 17 lands on 1.
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(i), 64'(i), 64'h0);
      step();
      if (i == 16) check("wrap16_cnt", {60'd0, retire_count}, 64'd0);
    end
    check("wrap17_cnt", {60'd0, retire_count}, 64'd1);

    // Bubble with regwrite set: no write; the valid one ahead still retires.
    drive(1'b0, 1'b1, 1'b0, 5'd7, 64'h77, 64'h0);
    step();
    check("bub_valid", {63'd0, bus.wb_valid}, 64'd0);
    check("bub_en",    {63'd0, bus.wb_en},    64'd0);
    check("bub_cnt",   {60'd0, retire_count}, 64'd2);
    step();
    check("bub2_cnt",  {60'd0, retire_count}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
